// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes
// them to instruction memory from BASE_ADDR, holding the core in reset until done.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [1:0]  byteIdx;
    logic [23:0] asmWord;
    logic [31:0] fullWord;
    logic [15:0] wordCount;
    logic [15:0] wordsLoaded;
    logic        accept;
    logic        lastByte;
    logic        rxReadyNxt;
    logic        weNxt;
    logic        holdNxt;
    logic        doneNxt;
    logic        errorNxt;

    assign accept       = rx_valid && rx_ready;
    assign lastByte     = accept && (byteIdx == 2'd3);
    assign fullWord     = {rx_data, asmWord};
    assign words_loaded = wordsLoaded;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) nextState = HDR;
            end
            HDR: begin
                if (lastByte) begin
                    if (fullWord == 32'd0 || fullWord > DEPTH_LIMIT) nextState = ERR;
                    else                                             nextState = DATA;
                end
            end
            DATA: begin
                if (lastByte) nextState = WRITE;
            end
            WRITE: begin
                if (wordsLoaded + 16'd1 == wordCount) nextState = DONE;
                else                                  nextState = DATA;
            end
            DONE, ERR: begin
                if (start) nextState = HDR;
            end
            default: nextState = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state and registered, so they
    // change on the same edge as the state and never depend on rx_valid.
    always_comb begin
        rxReadyNxt = (nextState == HDR) || (nextState == DATA);
        weNxt      = (nextState == WRITE);
        holdNxt    = (nextState != DONE);
        doneNxt    = (nextState == DONE);
        errorNxt   = (nextState == ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rx_ready  <= rxReadyNxt;
            imem_we   <= weNxt;
            core_hold <= holdNxt;
            done      <= doneNxt;
            error     <= errorNxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byteIdx     <= 2'd0;
            asmWord     <= 24'd0;
            wordCount   <= 16'd0;
            wordsLoaded <= 16'd0;
            imem_addr   <= BASE_ADDR;
            imem_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byteIdx     <= 2'd0;
                        wordsLoaded <= 16'd0;
                    end
                end
                HDR, DATA: begin
                    if (accept) begin
                        byteIdx <= byteIdx + 2'd1;
                        case (byteIdx)
                            2'd0:    asmWord[7:0]   <= rx_data;
                            2'd1:    asmWord[15:8]  <= rx_data;
                            2'd2:    asmWord[23:16] <= rx_data;
                            default: begin
                                if (state == HDR) begin
                                    wordCount <= fullWord[15:0];
                                end else begin
                                    imem_wdata <= fullWord;
                                    imem_addr  <= BASE_ADDR + {14'd0, wordsLoaded, 2'b00};
                                end
                            end
                        endcase
                    end
                end
                WRITE: begin
                    wordsLoaded <= wordsLoaded + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: drives byte-stream loads and compares the
// observed memory writes and status against an expected-write-list model.
module tb_imem_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] payload[$];
    logic [31:0] obsAddr[$];
    logic [31:0] obsData[$];

    imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            obsAddr.push_back(imem_addr);
            obsData.push_back(imem_wdata);
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte (after optional idle gaps) and holds it until it is taken.
    task automatic sendByte(input logic [7:0] b, input int gapPct);
        int n;
        while ($urandom_range(99) < gapPct) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkVal("rxAcceptTimeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int gapPct);
        for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8], gapPct);
    endtask

    function automatic bit headerBad(input logic [31:0] n);
        return (n == 32'd0) || (n > 32'(DEPTH));
    endfunction

    task automatic fillPayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back($urandom);
    endtask

    // Expected result: a bad header yields error with no writes; a good one
    // yields word i at BASE + 4*i for every payload word, then done.
    task automatic checkLoad(input logic [31:0] n, input string tag);
        bit expErr;
        int expCnt;
        int waitCnt;
        expErr  = headerBad(n);
        expCnt  = expErr ? 0 : int'(n);
        waitCnt = 0;
        while (!done && !error && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkVal({tag, ".done"}, 32'(done), 32'(!expErr));
        checkVal({tag, ".error"}, 32'(error), 32'(expErr));
        checkVal({tag, ".coreHold"}, 32'(core_hold), 32'(expErr));
        checkVal({tag, ".rxReady"}, 32'(rx_ready), 32'd0);
        checkVal({tag, ".writes"}, 32'(obsAddr.size()), 32'(expCnt));
        for (int i = 0; i < expCnt && i < obsAddr.size(); i++) begin
            checkVal({tag, ".addr"}, obsAddr[i], BASE + 32'(4 * i));
            checkVal({tag, ".data"}, obsData[i], payload[i]);
        end
        if (!expErr) checkVal({tag, ".wordsLoaded"}, 32'(words_loaded), n);
        obsAddr.delete();
        obsData.delete();
    endtask

    task automatic loadBody(input logic [31:0] n, input int gapPct);
        sendWord(n, gapPct);
        if (!headerBad(n)) begin
            for (int i = 0; i < int'(n); i++) sendWord(payload[i], gapPct);
        end
    endtask

    initial begin
        logic [31:0] w;
        int waitCnt;

        // Reset and idle behaviour, with a byte offered that must be ignored
        repeat (3) @(negedge clk);
        checkVal("rst.coreHold", 32'(core_hold), 32'd1);
        checkVal("rst.addr", imem_addr, BASE);
        checkVal("rst.wdata", imem_wdata, 32'd0);
        checkVal("rst.wordsLoaded", 32'(words_loaded), 32'd0);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkVal("idle.status", {27'd0, core_hold, rx_ready, done, error, imem_we}, 32'h10);
        end
        rx_valid = 1'b0;

        // Directed two-word load, back-to-back bytes
        payload.delete();
        payload.push_back(32'h00A00513);
        payload.push_back(32'h00100593);
        pulseStart();
        loadBody(32'd2, 0);
        checkLoad(32'd2, "twoWord");

        // Rejected headers
        pulseStart();
        checkVal("restartFromDone.done", 32'(done), 32'd0);
        loadBody(32'd0, 0);
        checkLoad(32'd0, "hdrZero");
        pulseStart();
        loadBody(32'd257, 0);
        checkLoad(32'd257, "hdrTooBig");

        // Full-depth load with random gaps
        fillPayload(DEPTH);
        pulseStart();
        loadBody(32'(DEPTH), 30);
        checkLoad(32'(DEPTH), "fullDepth");

        // Random small loads
        for (int k = 0; k < 4; k++) begin
            w = 32'($urandom_range(1, 12));
            fillPayload(int'(w));
            pulseStart();
            loadBody(w, 20);
            checkLoad(w, "rand");
        end

        // Reset after 3 of 5 words
        fillPayload(5);
        pulseStart();
        sendWord(32'd5, 0);
        for (int i = 0; i < 3; i++) sendWord(payload[i], 0);
        sendByte(payload[3][7:0], 0);
        waitCnt = 0;
        while (obsAddr.size() < 3 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        #2 reset = 1'b0;
        #1;
        checkVal("midRst.coreHold", 32'(core_hold), 32'd1);
        checkVal("midRst.rxReady", 32'(rx_ready), 32'd0);
        checkVal("midRst.wordsLoaded", 32'(words_loaded), 32'd0);
        checkVal("midRst.writes", 32'(obsAddr.size()), 32'd3);
        obsAddr.delete();
        obsData.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("postRst.rxReady", 32'(rx_ready), 32'd0);
        fillPayload(1);
        pulseStart();
        loadBody(32'd1, 0);
        checkLoad(32'd1, "afterRst");

        // start during DATA is ignored
        fillPayload(3);
        pulseStart();
        sendWord(32'd3, 0);
        sendWord(payload[0], 0);
        w = payload[1];
        sendByte(w[7:0], 0);
        pulseStart();
        checkVal("startInData.rxReady", 32'(rx_ready), 32'd1);
        for (int i = 1; i < 4; i++) sendByte(w[8*i +: 8], 0);
        sendWord(payload[2], 0);
        checkLoad(32'd3, "startInData");

        // start in DONE begins a new load
        pulseStart();
        checkVal("startInDone.done", 32'(done), 32'd0);
        checkVal("startInDone.coreHold", 32'(core_hold), 32'd1);
        checkVal("startInDone.rxReady", 32'(rx_ready), 32'd1);
        fillPayload(2);
        loadBody(32'd2, 10);
        checkLoad(32'd2, "reload");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from BASE_ADDR.
- Holds the processor core in reset while loading; releases it on successful completion.
- Sits between the external serial/byte-link front end and the instruction memory write port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; maximum accepted word count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse to begin a load.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  32  instruction memory byte address.
- imem_wdata  output  32  instruction memory write data.
- core_hold  output  1  high holds the core in reset.
- done  output  1  load completed successfully (sticky).
- error  output  1  header rejected (sticky).
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset values (reset low, asynchronous):
  - state = IDLE, rx_ready = 0, imem_we = 0.
  - imem_addr = BASE_ADDR, imem_wdata = 0.
  - core_hold = 1, done = 0, error = 0, words_loaded = 0.
  - Byte and word counters cleared.
- Byte accept: a byte is consumed only on the cycle where rx_valid = 1 and rx_ready = 1.
  - rx_ready is high only in HDR and DATA, registered from the state.
  - rx_ready does not depend combinationally on rx_valid.
- Byte assembly: byte index b = 0..3; byte b goes to bits [8b+7:8b] (little-endian). b wraps 3 -> 0.
- State machine:
  - IDLE: core_hold = 1. start -> HDR; clear done, error, words_loaded and counters.
  - HDR: collect 4 bytes into a 32-bit word count N. On the 4th byte:
    - N == 0 or N > DEPTH_WORDS -> ERR.
    - Otherwise latch N[15:0] and go to DATA.
  - DATA: collect 4 bytes. On the 4th accepted byte -> WRITE.
  - WRITE: exactly one cycle.
    - imem_we = 1, imem_addr = BASE_ADDR + 4*words_loaded, imem_wdata = assembled word, rx_ready = 0.
    - Next cycle: words_loaded += 1.
    - If the new words_loaded == N -> DONE, else -> DATA.
  - DONE: done = 1, core_hold = 0, rx_ready = 0. start -> HDR; done clears and core_hold returns to 1 on the same edge.
  - ERR: error = 1, core_hold = 1, rx_ready = 0. start -> HDR; error clears.
- imem_we is high only in WRITE. imem_addr and imem_wdata are registered and stable for that whole cycle.
- Throughput: 4 accepted bytes + 1 WRITE cycle per word, so the minimum is 5 cycles/word with rx_valid held high.
- start is ignored in HDR, DATA and WRITE; it does not restart a load in progress.
- rx_valid with rx_ready = 0 is ignored. Bytes present in IDLE/DONE/ERR are not consumed.
- Gaps: rx_valid may drop at any byte boundary; partial-word state is held indefinitely with no timeout.
- Reset mid-load: immediate return to IDLE with core_hold = 1. Words already written stay in memory (no rollback). The next load requires start.
- Boundary: N == DEPTH_WORDS is accepted. The last write address is BASE_ADDR + 4*(DEPTH_WORDS-1).
- words_loaded is 16 bits, so DEPTH_WORDS must be <= 65535.

Test Plan:
- Reset asserted, then released, no start -> core_hold = 1, rx_ready = 0, done = 0, error = 0, imem_we = 0 for 20 cycles.
- start; bytes 02 00 00 00, 13 05 A0 00, 93 05 10 00 back-to-back -> two WRITE pulses:
  - addr 0x0 data 0x00A00513.
  - addr 0x4 data 0x00100593.
  - Then done = 1, core_hold = 0, words_loaded = 2.
- Header 00 00 00 00 -> error = 1, core_hold = 1, no imem_we. Header 01 01 00 00 (257, DEPTH_WORDS = 256) -> error = 1.
- N = 256 with random rx_valid gaps (~30% idle) -> 256 writes at addresses 0x000..0x3FC with correct data, done = 1. Bytes offered while rx_ready = 0 are not consumed.
- Reset asserted after 3 of 5 words written -> immediate IDLE, core_hold = 1. start + fresh N = 1 load -> rewrites addr 0x0, done = 1.
- start pulsed during DATA -> ignored and the load completes normally. start in DONE -> done clears, core_hold = 1, new header is accepted.
